// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/acknowledge bus between the MAR/MBR requester and mem_responder
interface mem_responder_if;
  logic [7:0]  i_mar_mem;
  logic [15:0] i_mbr_mem;
  logic        i_rd;
  logic        i_wr;
  logic [15:0] o_mem_mbr;
  logic        o_ack;
  logic        o_busy;
  logic        o_err;

  // Requester side: drives address, data and request levels, receives completion
  modport master (
    output i_mar_mem, i_mbr_mem, i_rd, i_wr,
    input  o_mem_mbr, o_ack, o_busy, o_err
  );

  // Memory side
  modport slave (
    input  i_mar_mem, i_mbr_mem, i_rd, i_wr,
    output o_mem_mbr, o_ack, o_busy, o_err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 256x16 memory responder with wait states and one-cycle ack pulse
// Optional feature: define MEM_WP_EN to reject writes below WP_LIMIT with o_err.
module mem_responder #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  WP_LIMIT    = 8'h10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;

  // Captured request, frozen at acceptance so later input changes cannot leak in
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        err_q;

  // Registered outputs
  logic [15:0] mbr_q;
  logic        ack_q, busy_q, errf_q;
  logic [15:0] mbr_d;
  logic        ack_d, busy_d, errf_d;

  // Storage is deliberately outside the reset domain so contents survive reset
  logic [15:0] mem [256];

  logic        req_any;
  logic        in_wr_only;
  logic        wp_hit;
  logic        in_err;
  logic [7:0]  sel_addr;
  logic [15:0] sel_data;
  logic        sel_wr;
  logic        sel_err;
  logic        enter_ack;
  logic        mem_we;

  assign req_any    = bus.i_rd | bus.i_wr;
  assign in_wr_only = bus.i_wr & ~bus.i_rd;

`ifdef MEM_WP_EN
  assign wp_hit = in_wr_only & (bus.i_mar_mem < WP_LIMIT);
`else
  assign wp_hit = 1'b0 & (bus.i_mar_mem < WP_LIMIT);
`endif

  // Both requests high is an error transaction; so is a protected write
  assign in_err = (bus.i_rd & bus.i_wr) | wp_hit;

  // With zero wait states the commit happens on the accepting edge, so the live
  // inputs are used there; otherwise the captured copy drives the commit
  assign sel_addr = (state == S_IDLE) ? bus.i_mar_mem : addr_q;
  assign sel_data = (state == S_IDLE) ? bus.i_mbr_mem : wdata_q;
  assign sel_wr   = (state == S_IDLE) ? in_wr_only    : wr_q;
  assign sel_err  = (state == S_IDLE) ? in_err        : err_q;

  assign enter_ack = (state_d == S_ACK) && (state != S_ACK);
  assign mem_we    = enter_ack & sel_wr & ~sel_err & i_rst_n;

  // Next-state, wait counter and next registered output values
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack_d  = enter_ack;
    busy_d = (state_d != S_IDLE);
    errf_d = enter_ack & sel_err;
    mbr_d  = (enter_ack && !sel_wr && !sel_err) ? mem[sel_addr] : 16'h0000;
  end

  // State, counter, request capture and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      mbr_q   <= 16'h0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      errf_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      mbr_q  <= mbr_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      errf_q <= errf_d;
      if (state == S_IDLE && req_any) begin
        addr_q  <= bus.i_mar_mem;
        wdata_q <= bus.i_mbr_mem;
        wr_q    <= in_wr_only;
        err_q   <= in_err;
      end
    end
  end

  // Memory write commits on the edge entering ACK
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[sel_addr] <= sel_data;
    end
  end

  assign bus.o_mem_mbr = mbr_q;
  assign bus.o_ack     = ack_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_err     = errf_q;

endmodule
